// File: rtl/apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
// Shared definitions for the FIFO-fed APB requester:
//   - apb_state_e : requester FSM states
//   - apb_req_t   : request FIFO entry {write, addr, wdata, strb, prot}
//   - apb_resp_t  : response FIFO entry {write, slverr, rdata}
//   - REQ_W / RESP_W for the default 32-bit address/data configuration
//   - req_width()/resp_width() to size the FIFO ports of other configurations
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int PROT_W      = 3;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                      write;
      logic [ADDR_W_DEF-1:0]     addr;
      logic [DATA_W_DEF-1:0]     wdata;
      logic [DATA_W_DEF/8-1:0]   strb;
      logic [PROT_W-1:0]         prot;
   } apb_req_t;

   typedef struct packed {
      logic                      write;
      logic                      slverr;
      logic [DATA_W_DEF-1:0]     rdata;
   } apb_resp_t;

   localparam int REQ_W  = $bits(apb_req_t);
   localparam int RESP_W = $bits(apb_resp_t);

   // Request entry width for an arbitrary address/data configuration.
   function automatic int req_width(input int aw, input int dw);
      return 1 + aw + dw + (dw / 8) + PROT_W;
   endfunction

   // Response entry width for an arbitrary data configuration.
   function automatic int resp_width(input int dw);
      return 2 + dw;
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
// Counts ACCESS cycles in which the completer has not yet answered.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous active-high reset
//   clear   in  return count to zero (has priority over enable)
//   enable  in  one more waited ACCESS cycle
//   expired out high in the waited cycle whose count step reaches TIMEOUT-1;
//               the requester aborts on that edge, so a transfer that never
//               sees pready spends exactly TIMEOUT-1 cycles in ACCESS
// -----------------------------------------------------------------------------
module apb_timeout_cnt
   import apb_bridge_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 2);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // next count: clear wins, otherwise step on every waited cycle
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = 8'd0;
      end else if (enable) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable & (cnt_q == LAST_WAIT);

endmodule

// File: rtl/apb_req_master.sv
// -----------------------------------------------------------------------------
// apb_req_master
// Pops requests from a request FIFO, runs each as one APB transfer and pushes
// one response per request into a response FIFO, strictly in order.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_empty, req_data, req_rd  request FIFO head / pop strobe
//   resp_full, resp_wr, resp_data response FIFO push side {write,slverr,rdata}
//   psel, penable, pwrite, paddr, pwdata, pstrb, pprot   APB requester outputs
//   pready, pslverr, prdata      APB completer response
// Transfers abort with slverr=1, rdata=0 after TIMEOUT-1 unanswered ACCESS
// cycles.
// -----------------------------------------------------------------------------
module apb_req_master
   import apb_bridge_pkg::*;
#(
   parameter  int ADDR_WIDTH = ADDR_W_DEF,
   parameter  int DATA_WIDTH = DATA_W_DEF,
   parameter  int TIMEOUT    = TIMEOUT_DEF,
   localparam int STRB_W     = DATA_WIDTH / 8,
   localparam int REQ_WL     = req_width(ADDR_WIDTH, DATA_WIDTH),
   localparam int RESP_WL    = resp_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_empty,
   input  logic [REQ_WL-1:0]     req_data,
   output logic                  req_rd,
   input  logic                  resp_full,
   output logic                  resp_wr,
   output logic [RESP_WL-1:0]    resp_data,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic [STRB_W-1:0]     pstrb,
   output logic [PROT_W-1:0]     pprot,
   input  logic                  pready,
   input  logic                  pslverr,
   input  logic [DATA_WIDTH-1:0] prdata
);

   // request entry field positions, prot in the LSBs, write in the MSB
   localparam int PROT_LSB  = 0;
   localparam int STRB_LSB  = PROT_LSB + PROT_W;
   localparam int WDATA_LSB = STRB_LSB + STRB_W;
   localparam int ADDR_LSB  = WDATA_LSB + DATA_WIDTH;
   localparam int WRITE_BIT = ADDR_LSB + ADDR_WIDTH;

   apb_state_e            state_q, state_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [STRB_W-1:0]     pstrb_q, pstrb_d;
   logic [PROT_W-1:0]     pprot_q, pprot_d;
   logic                  slverr_q, slverr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  in_access;
   logic                  tmo_clear;
   logic                  tmo_enable;
   logic                  tmo_expired;

   // pready and friends only matter while in ACCESS
   assign in_access  = (state_q == ST_ACCESS);
   assign tmo_enable = in_access & ~pready;
   assign tmo_clear  = ~in_access | pready;

   apb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = req_empty ? ST_IDLE : ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: state_d = (pready | tmo_expired) ? ST_RESP : ST_ACCESS;
         ST_RESP:   state_d = resp_full ? ST_RESP : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; FIFO strobes are gated by rst so nothing moves during reset
   always_comb begin
      psel    = 1'b0;
      penable = 1'b0;
      req_rd  = 1'b0;
      resp_wr = 1'b0;
      case (state_q)
         ST_IDLE:   req_rd  = ~rst & ~req_empty;
         ST_SETUP:  psel    = 1'b1;
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         ST_RESP:   resp_wr = ~rst & ~resp_full;
         default: begin
            psel    = 1'b0;
            penable = 1'b0;
            req_rd  = 1'b0;
            resp_wr = 1'b0;
         end
      endcase
   end

   // request latch on pop, response capture on completion or abort
   always_comb begin
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      pprot_d  = pprot_q;
      slverr_d = slverr_q;
      rdata_d  = rdata_q;
      if (req_rd) begin
         pwrite_d = req_data[WRITE_BIT];
         paddr_d  = req_data[ADDR_LSB +: ADDR_WIDTH];
         pwdata_d = req_data[WDATA_LSB +: DATA_WIDTH];
         // reads never carry strobes
         pstrb_d  = req_data[WRITE_BIT] ? req_data[STRB_LSB +: STRB_W] : {STRB_W{1'b0}};
         pprot_d  = req_data[PROT_LSB +: PROT_W];
      end else begin
         pwrite_d = pwrite_q;
      end
      if (in_access & pready) begin
         slverr_d = pslverr;
         rdata_d  = pwrite_q ? {DATA_WIDTH{1'b0}} : prdata;
      end else if (tmo_expired) begin
         slverr_d = 1'b1;
         rdata_d  = {DATA_WIDTH{1'b0}};
      end else begin
         slverr_d = slverr_q;
      end
   end

   // request and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pwrite_q <= 1'b0;
         paddr_q  <= {ADDR_WIDTH{1'b0}};
         pwdata_q <= {DATA_WIDTH{1'b0}};
         pstrb_q  <= {STRB_W{1'b0}};
         pprot_q  <= {PROT_W{1'b0}};
         slverr_q <= 1'b0;
         rdata_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pstrb_q  <= pstrb_d;
         pprot_q  <= pprot_d;
         slverr_q <= slverr_d;
         rdata_q  <= rdata_d;
      end
   end

   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign pstrb     = pstrb_q;
   assign pprot     = pprot_q;
   assign resp_data = {pwrite_q, slverr_q, rdata_q};

endmodule

// File: doc/apb_req_master.md
APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 Parameter ADDR_WIDTH, 32, APB address width.
REQ-002 Parameter DATA_WIDTH, 32, APB data width; PSTRB width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; legal range 2..255.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_empty  in  1  request FIFO empty flag.
REQ-008 req_data  in  REQ_W  request FIFO head entry, combinationally valid while req_empty=0; fields {write, addr, wdata, strb, prot[2:0]}.
REQ-009 req_rd  out  1  pop strobe to request FIFO.
REQ-010 resp_full  in  1  response FIFO full flag.
REQ-011 resp_wr  out  1  push strobe to response FIFO.
REQ-012 resp_data  out  RESP_W  response entry {write, slverr, rdata[DATA_WIDTH-1:0]}.
REQ-013 psel, penable, pwrite  out  1 each  APB control.
REQ-014 paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH; pstrb  out  DATA_WIDTH/8; pprot  out  3  APB request fields.
REQ-015 pready, pslverr  in  1 each; prdata  in  DATA_WIDTH  APB completer response.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; exactly one state active.
REQ-017 IDLE: req_rd SHALL equal ~req_empty combinationally; on that edge the block latches req_data into APB output registers and moves to SETUP, else it stays in IDLE.
REQ-018 SETUP: psel=1, penable=0; unconditional move to ACCESS next edge.
REQ-019 ACCESS: psel=1, penable=1; on pready=1, capture slverr=pslverr and rdata=(pwrite ? 0 : prdata), clear timeout counter, move to RESP.
REQ-020 Timeout counter SHALL increment each ACCESS cycle with pready=0; when it reaches TIMEOUT-1 with pready=0, the block captures slverr=1 and rdata=0, then moves to RESP (abort).
REQ-021 RESP: psel=penable=0; resp_wr=~resp_full combinationally; on push, move to IDLE; while resp_full=1, hold resp_data stable and remain in RESP.
REQ-022 paddr, pwrite, pwdata, pstrb, pprot SHALL stay stable from SETUP through the last ACCESS cycle; pstrb SHALL be driven 0 when pwrite=0.
REQ-023 Minimum latency: req_empty falls in cycle 0 -> req_rd cycle 0, SETUP cycle 1, ACCESS cycle 2, resp_wr cycle 3 (pready=1, resp_full=0); throughput one transfer per 4 cycles.
REQ-024 Exactly one resp_wr per req_rd; responses SHALL leave in request order.
REQ-025 The block SHALL sample pready, prdata, and pslverr only in ACCESS; values in other states SHALL be ignored.
REQ-026 req_rd and resp_wr SHALL never both be 1 in the same cycle.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL enter IDLE, clear the timeout counter, and drive all outputs and registered fields to 0.
REQ-028 If reset arrives mid-transfer, psel SHALL drop at that edge, and the in-flight request SHALL be discarded with no resp_wr.
REQ-029 While rst=1, req_rd and resp_wr SHALL be 0 regardless of FIFO flags.

Structure
REQ-030 Shared package apb_bridge_pkg SHALL hold the state enum, request and response packed-struct typedefs, the REQ_W/RESP_W widths, and the default TIMEOUT.
REQ-031 The timeout counter SHALL be one sub-module, apb_timeout_cnt (inputs: clear, enable; output: expired).
REQ-032 No storage beyond one latched request and one response register; buffering is provided by the external FIFOs.

Verification
REQ-033 Write: req {write=1, addr=0x10, wdata=0xA5A5_5A5A, strb=0xF}, pready=1 in first ACCESS -> psel cycles 1-2, penable cycle 2, resp {1,0,0} on cycle 3.
REQ-034 Read with 3 wait states: addr=0x20, prdata=0xDEAD_BEEF with pslverr=1 on 4th ACCESS cycle -> resp {0,1,0xDEAD_BEEF}, paddr stable throughout.
REQ-035 Timeout: pready held 0, TIMEOUT=16 -> exactly 15 ACCESS cycles, then resp {x,1,0}, FSM returns to IDLE.
REQ-036 Backpressure: resp_full=1 for 5 cycles in RESP -> no resp_wr and resp_data stable; push on the first cycle resp_full=0; no req_rd meanwhile.
REQ-037 Back-to-back: 4 queued requests -> req_rd every 4th cycle, 4 in-order responses, no idle gap beyond the RESP->IDLE cycle.
REQ-038 Reset in ACCESS -> psel=0 next cycle, no resp_wr, next queued request starts cleanly from IDLE.
